// File: rtl/mux_pkg.sv
// Shared types and constants for the registered N-to-1 sampling mux.
package mux_pkg;

    typedef enum logic {IDLE, HOLD} mux_state_t;

    localparam logic MUX_MODE_MANUAL = 1'b0;
    localparam logic MUX_MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_ptr.sv
// Round-robin scan pointer: advances on adv, wraps at N_CH-1 with a one-cycle
// wrap pulse, and restarts from channel 0 when restart is high.
module scan_ptr
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             restart,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap
);

    logic [SEL_W-1:0] ptr_q, ptr_d, cur;
    logic             wrap_q, wrap_d;

    // restart forces the current position to 0 so a same-cycle capture uses channel 0
    always_comb begin
        cur    = restart ? '0 : ptr_q;
        ptr_d  = cur;
        wrap_d = 1'b0;
        if (adv) begin
            if (cur == SEL_W'(N_CH - 1)) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = cur + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 channel mux with manual/auto-scan select and valid/ready output.
// Define MUX_PARITY_EN to add the registered even-parity output out_par_o.
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  mode_i,
    input  logic                  en_i,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SEL_W-1:0]      out_ch_o,
    output logic                  out_valid_o,
    output logic                  sel_err_o,
    output logic                  scan_wrap_o
`ifdef MUX_PARITY_EN
    ,
    output logic                  out_par_o
`endif
);

    mux_state_t       state_q;
    logic             mode_q;
    logic             scan_mode, mode_rise, cap;
    logic [SEL_W-1:0] ptr, idx;
    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q, err_q;
`ifdef MUX_PARITY_EN
    logic             par_q;
`endif

    assign scan_mode = (mode_i == MUX_MODE_SCAN);
    assign mode_rise = scan_mode && (mode_q == MUX_MODE_MANUAL);
    assign cap       = en_i && ((state_q == IDLE) || out_ready_i);
    assign idx       = scan_mode ? (mode_rise ? '0 : ptr) : sel_i;

    // An index with no matching channel yields zero data and flags the error
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == k[SEL_W-1:0]) begin
                sel_data = data_i[k*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
    end

    scan_ptr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_scan_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (cap && scan_mode),
        .restart (mode_rise),
        .ptr     (ptr),
        .wrap    (scan_wrap_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MUX_MODE_MANUAL;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MUX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            mode_q <= mode_i;
            if (cap) begin
                data_q <= sel_data;
                ch_q   <= idx;
                err_q  <= !sel_hit;
`ifdef MUX_PARITY_EN
                par_q  <= ^sel_data;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i && !en_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_data_o  = data_q;
    assign out_ch_o    = ch_q;
    assign out_valid_o = valid_q;
    assign sel_err_o   = err_q;
`ifdef MUX_PARITY_EN
    assign out_par_o   = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: a 4x8 instance for the main paths and a
// 3x4 instance for out-of-range select and non-power-of-2 scan wrap.
module tb_mux_nto1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] d4;
    logic [1:0]  s4;
    logic        m4, e4, r4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic        ov4, oe4, ow4;

    logic [11:0] d3;
    logic [1:0]  s3;
    logic        m3, e3, r3;
    logic [3:0]  od3;
    logic [1:0]  oc3;
    logic        ov3, oe3, ow3;
`ifdef MUX_PARITY_EN
    logic        op4, op3;
`endif

    mux_nto1_reg #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_i(d4), .sel_i(s4), .mode_i(m4), .en_i(e4),
        .out_ready_i(r4), .out_data_o(od4), .out_ch_o(oc4), .out_valid_o(ov4),
`ifdef MUX_PARITY_EN
        .out_par_o(op4),
`endif
        .sel_err_o(oe4), .scan_wrap_o(ow4)
    );

    mux_nto1_reg #(.N_CH(3), .WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_i(d3), .sel_i(s3), .mode_i(m3), .en_i(e3),
        .out_ready_i(r3), .out_data_o(od3), .out_ch_o(oc3), .out_valid_o(ov3),
`ifdef MUX_PARITY_EN
        .out_par_o(op3),
`endif
        .sel_err_o(oe3), .scan_wrap_o(ow3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // channel k is the k-th byte from the LSB end
    function automatic logic [7:0] byte_of(input logic [31:0] d, input int k);
        return d[8*k +: 8];
    endfunction

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       rdy;
        logic [7:0] e_data;
        logic [1:0] e_ch;
        logic       e_valid;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] hold_d;
        int         exp_ch;

        tbl[0] = '{2'd2, 1'b1, 1'b1, 8'hC3, 2'd2, 1'b1};
        tbl[1] = '{2'd0, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b1};
        tbl[2] = '{2'd3, 1'b0, 1'b1, 8'hA1, 2'd0, 1'b0};
        tbl[3] = '{2'd3, 1'b1, 1'b0, 8'hD4, 2'd3, 1'b1};
        tbl[4] = '{2'd1, 1'b1, 1'b0, 8'hD4, 2'd3, 1'b1};
        tbl[5] = '{2'd1, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b1};

        rst_n = 1'b0;
        d4 = 32'hD4C3B2A1; s4 = 2'd2; m4 = 1'b0; e4 = 1'b1; r4 = 1'b1;
        d3 = 12'h5A7;      s3 = 2'd1; m3 = 1'b0; e3 = 1'b1; r3 = 1'b1;
        #12;
        chk("rst data4", 32'(od4), 32'h0);
        chk("rst ch4", 32'(oc4), 32'h0);
        chk("rst valid4", 32'(ov4), 32'h0);
        chk("rst err4", 32'(oe4), 32'h0);
        chk("rst wrap4", 32'(ow4), 32'h0);
        chk("rst valid3", 32'(ov3), 32'h0);
        chk("rst data3", 32'(od3), 32'h0);

        step();
        e4 = 1'b0; e3 = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle valid4", 32'(ov4), 32'h0);
            chk("idle valid3", 32'(ov3), 32'h0);
        end

        for (int i = 0; i < 6; i++) begin
            s4 = tbl[i].sel; e4 = tbl[i].en; r4 = tbl[i].rdy;
            step();
            chk("tbl data", 32'(od4), 32'(tbl[i].e_data));
            chk("tbl ch", 32'(oc4), 32'(tbl[i].e_ch));
            chk("tbl valid", 32'(ov4), 32'(tbl[i].e_valid));
            chk("tbl wrap", 32'(ow4), 32'h0);
        end

        e4 = 1'b1; r4 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s4 = 2'($urandom_range(3));
            d4 = $urandom;
            step();
            chk("rand data", 32'(od4), 32'(byte_of(d4, int'(s4))));
            chk("rand ch", 32'(oc4), 32'(s4));
            chk("rand err", 32'(oe4), 32'h0);
        end

        d4 = 32'hD4C3B2A1; s4 = 2'd1;
        step();
        chk("bp first", 32'(od4), 32'hB2);
        hold_d = od4;
        r4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom;
            s4 = 2'(i + 2);
            step();
            chk("bp data", 32'(od4), 32'(hold_d));
            chk("bp ch", 32'(oc4), 32'h1);
            chk("bp valid", 32'(ov4), 32'h1);
        end
        d4 = 32'h11223344; s4 = 2'd3; r4 = 1'b1;
        step();
        chk("bp release data", 32'(od4), 32'h11);
        chk("bp release ch", 32'(oc4), 32'h3);

        d4 = 32'hD4C3B2A1; m4 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_ch = i % 4;
            chk("scan ch", 32'(oc4), 32'(exp_ch));
            chk("scan data", 32'(od4), 32'(byte_of(d4, exp_ch)));
            chk("scan wrap", 32'(ow4), (exp_ch == 3) ? 32'h1 : 32'h0);
        end

        step();
        chk("restart pre ch", 32'(oc4), 32'h1);
        m4 = 1'b0; e4 = 1'b0;
        step();
        chk("restart idle valid", 32'(ov4), 32'h0);
        m4 = 1'b1; e4 = 1'b1;
        step();
        chk("restart ch", 32'(oc4), 32'h0);
        chk("restart data", 32'(od4), 32'hA1);
        step();
        chk("restart next ch", 32'(oc4), 32'h1);

        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(ov4), 32'h0);
        chk("midrst data", 32'(od4), 32'h0);
        chk("midrst ch", 32'(oc4), 32'h0);
        e4 = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        e4 = 1'b1;
        step();
        chk("postrst ch", 32'(oc4), 32'h0);
        chk("postrst valid", 32'(ov4), 32'h1);
        step();
        chk("postrst next ch", 32'(oc4), 32'h1);
        e4 = 1'b0;

        s3 = 2'd3; e3 = 1'b1; r3 = 1'b1;
        step();
        chk("oor data", 32'(od3), 32'h0);
        chk("oor err", 32'(oe3), 32'h1);
        chk("oor valid", 32'(ov3), 32'h1);
        chk("oor ch", 32'(oc3), 32'h3);
        s3 = 2'd1;
        step();
        chk("inr data", 32'(od3), 32'hA);
        chk("inr err", 32'(oe3), 32'h0);

        m3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_ch = i % 3;
            chk("scan3 ch", 32'(oc3), 32'(exp_ch));
            chk("scan3 wrap", 32'(ow3), (exp_ch == 2) ? 32'h1 : 32'h0);
            chk("scan3 err", 32'(oe3), 32'h0);
        end
        e3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
